// File: rtl/mem_ctrl_burst.sv
// Byte-serial RAM/UART bus controller: round-robin arbitration between ICache
// line fills and LSB loads/stores, with load extension and UART-full write stalls.
module mem_ctrl_burst #(
    parameter int          ADDR_W     = 18,
    parameter int          LINE_BYTES = 8,
    parameter logic [31:0] IO_BASE    = 32'h30000
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    rdy_in,
    input  logic                    uart_full_in,
    input  logic [7:0]              ram_din,
    output logic [7:0]              ram_dout,
    output logic [ADDR_W-1:0]       ram_a,
    output logic                    ram_rnw,
    input  logic                    ic_req,
    input  logic [31:0]             ic_addr,
    output logic                    ic_resp,
    output logic [8*LINE_BYTES-1:0] ic_line,
    input  logic                    lsb_req,
    input  logic                    lsb_we,
    input  logic [31:0]             lsb_addr,
    input  logic [1:0]              lsb_size,
    input  logic                    lsb_signed,
    input  logic [31:0]             lsb_wdata,
    output logic                    lsb_resp,
    output logic [31:0]             lsb_rdata,
    output logic [2:0]              dbg_state
);
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int CNT_W  = $clog2(LINE_BYTES) + 1;

    // Handshake: a requester raises req (level) and holds it with stable fields
    // until its resp pulses for one cycle; it then drops req during the GAP cycle.
    typedef enum logic [2:0] {IDLE, GAP, RD, WR, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, nbytes_q, lsb_n;
    logic [ADDR_W-1:0]   base_q, ram_a_q;
    logic [23:0]         wdata_hi_q;
    logic [1:0]          size_q;
    logic                src_ic_q, io_q, signed_q, last_ic_q, rnw_q;
    logic [7:0]          ram_dout_q, next_wbyte;
    logic                ic_resp_q, lsb_resp_q;
    logic [LINE_W-1:0]   ic_line_q, buf_q, fill_data;
    logic [31:0]         lsb_rdata_q, load_ext;
    logic                grant_ic, grant_lsb, stall;
    logic                unused_ic_addr;

    assign unused_ic_addr = ^ic_addr[31:ADDR_W];

    assign stall = (state_q == WR) && io_q && uart_full_in;

    always_comb begin
        state_d   = state_q;
        grant_ic  = 1'b0;
        grant_lsb = 1'b0;
        case (state_q)
            IDLE: begin
                if (ic_req && lsb_req) begin
                    if (last_ic_q) grant_lsb = 1'b1;
                    else           grant_ic  = 1'b1;
                end else if (ic_req) begin
                    grant_ic = 1'b1;
                end else if (lsb_req) begin
                    grant_lsb = 1'b1;
                end
                if (grant_ic)       state_d = RD;
                else if (grant_lsb) state_d = lsb_we ? WR : RD;
            end
            RD:      if (cnt_q == nbytes_q) state_d = DONE;
            WR:      if (!stall && cnt_q == nbytes_q - CNT_W'(1)) state_d = DONE;
            DONE:    state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (lsb_size)
            2'd0:    lsb_n = CNT_W'(1);
            2'd1:    lsb_n = CNT_W'(2);
            default: lsb_n = CNT_W'(4);
        endcase
        case (cnt_q[1:0])
            2'd0:    next_wbyte = wdata_hi_q[7:0];
            2'd1:    next_wbyte = wdata_hi_q[15:8];
            default: next_wbyte = wdata_hi_q[23:16];
        endcase
    end

    // Byte k arrives on ram_din while cnt_q == k+1; merge it into the line buffer.
    always_comb begin
        fill_data = buf_q;
        for (int k = 0; k < LINE_BYTES; k++) begin
            if (CNT_W'(k + 1) == cnt_q) fill_data[8*k +: 8] = ram_din;
        end
        case (size_q)
            2'd0:    load_ext = {{24{signed_q & fill_data[7]}}, fill_data[7:0]};
            2'd1:    load_ext = {{16{signed_q & fill_data[15]}}, fill_data[15:0]};
            default: load_ext = fill_data[31:0];
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            nbytes_q    <= '0;
            base_q      <= '0;
            ram_a_q     <= '0;
            wdata_hi_q  <= '0;
            size_q      <= '0;
            src_ic_q    <= 1'b0;
            io_q        <= 1'b0;
            signed_q    <= 1'b0;
            last_ic_q   <= 1'b1;
            rnw_q       <= 1'b1;
            ram_dout_q  <= '0;
            ic_resp_q   <= 1'b0;
            lsb_resp_q  <= 1'b0;
            ic_line_q   <= '0;
            lsb_rdata_q <= '0;
            buf_q       <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            ic_resp_q  <= 1'b0;
            lsb_resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_ic || grant_lsb) begin
                        last_ic_q <= grant_ic;
                        src_ic_q  <= grant_ic;
                        cnt_q     <= '0;
                        if (grant_ic) begin
                            base_q   <= ic_addr[ADDR_W-1:0];
                            ram_a_q  <= ic_addr[ADDR_W-1:0];
                            nbytes_q <= CNT_W'(LINE_BYTES);
                            io_q     <= 1'b0;
                            rnw_q    <= 1'b1;
                        end else begin
                            base_q     <= lsb_addr[ADDR_W-1:0];
                            ram_a_q    <= lsb_addr[ADDR_W-1:0];
                            nbytes_q   <= lsb_n;
                            io_q       <= (lsb_addr >= IO_BASE);
                            wdata_hi_q <= lsb_wdata[31:8];
                            size_q     <= lsb_size;
                            signed_q   <= lsb_signed;
                            rnw_q      <= !lsb_we;
                            ram_dout_q <= lsb_we ? lsb_wdata[7:0] : 8'h00;
                        end
                    end
                end
                RD: begin
                    buf_q <= fill_data;
                    if (cnt_q == nbytes_q) begin
                        ram_a_q <= '0;
                        if (src_ic_q) begin
                            ic_line_q <= fill_data;
                            ic_resp_q <= 1'b1;
                        end else begin
                            lsb_rdata_q <= load_ext;
                            lsb_resp_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        ram_a_q <= (cnt_q + CNT_W'(1) < nbytes_q)
                                   ? base_q + ADDR_W'(cnt_q) + ADDR_W'(1) : '0;
                    end
                end
                WR: begin
                    // A stalled cycle leaves the byte index and bus registers untouched.
                    if (!stall) begin
                        if (cnt_q == nbytes_q - CNT_W'(1)) begin
                            rnw_q      <= 1'b1;
                            ram_a_q    <= '0;
                            ram_dout_q <= '0;
                            lsb_resp_q <= 1'b1;
                        end else begin
                            cnt_q      <= cnt_q + CNT_W'(1);
                            ram_a_q    <= base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
                            ram_dout_q <= next_wbyte;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    assign ram_rnw   = rnw_q | stall;
    assign ic_resp   = ic_resp_q;
    assign ic_line   = ic_line_q;
    assign lsb_resp  = lsb_resp_q;
    assign lsb_rdata = lsb_rdata_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_ctrl_burst.sv
// Bench for mem_ctrl_burst: byte RAM/UART model, driver tasks, expected-result
// queues popped on each resp, and a one-line summary.
module tb_mem_ctrl_burst;
    localparam int          AW  = 18;
    localparam int          LB  = 8;
    localparam logic [31:0] IOB = 32'h30000;
    localparam logic [2:0]  ST_IDLE = 3'd0, ST_GAP = 3'd1, ST_RD = 3'd2, ST_WR = 3'd3, ST_DONE = 3'd4;

    logic            clk_in = 1'b0;
    logic            rst_n_in, rdy_in, uart_full_in;
    logic [7:0]      ram_din = 8'h00;
    logic [7:0]      ram_dout;
    logic [AW-1:0]   ram_a;
    logic            ram_rnw;
    logic            ic_req;
    logic [31:0]     ic_addr;
    logic            ic_resp;
    logic [8*LB-1:0] ic_line;
    logic            lsb_req, lsb_we, lsb_signed, lsb_resp;
    logic [31:0]     lsb_addr, lsb_wdata, lsb_rdata;
    logic [1:0]      lsb_size;
    logic [2:0]      dbg_state;

    mem_ctrl_burst #(.ADDR_W(AW), .LINE_BYTES(LB), .IO_BASE(IOB)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .uart_full_in(uart_full_in),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_rnw(ram_rnw),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_resp(ic_resp), .ic_line(ic_line),
        .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
        .lsb_signed(lsb_signed), .lsb_wdata(lsb_wdata), .lsb_resp(lsb_resp),
        .lsb_rdata(lsb_rdata), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk_in = ~clk_in;
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] lsb_exp_q[$];
    logic [63:0] ic_exp_q[$];
    logic [31:0] last_lsb_exp = 32'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RAM / UART model, frozen together with the rest of the system by rdy_in
    logic [7:0] ram [0:(1<<AW)-1];
    logic [7:0] uart_q[$];
    always @(posedge clk_in) begin
        if (rdy_in) begin
            ram_din <= ram[ram_a];
            if (!ram_rnw) begin
                if ({{(32-AW){1'b0}}, ram_a} >= IOB) uart_q.push_back(ram_dout);
                else ram[ram_a] <= ram_dout;
            end
        end
    end

    function automatic logic [31:0] load_model(input logic [31:0] addr, input logic [1:0] size,
                                               input logic sgn);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ram[AW'(addr + 32'(i))];
        case (size)
            2'd0:    return sgn ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
            2'd1:    return sgn ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [63:0] line_model(input logic [31:0] addr);
        logic [63:0] l;
        for (int k = 0; k < LB; k++) l[8*k +: 8] = ram[AW'(addr + 32'(k))];
        return l;
    endfunction

    // scoreboard monitor: accept-cycle tracking and data compare on each resp edge
    int          a_cyc = 0;
    logic [2:0]  mon_prev = ST_IDLE;
    logic        mon_lr = 1'b0, mon_ir = 1'b0;
    always @(negedge clk_in) begin
        if ((dbg_state == ST_RD || dbg_state == ST_WR) && mon_prev == ST_IDLE) a_cyc = cyc;
        if (lsb_resp && !mon_lr) begin
            if (lsb_exp_q.size() == 0) check("lsb_resp_unexpected", lsb_resp, 0);
            else check("lsb_rdata", lsb_rdata, lsb_exp_q.pop_front());
        end
        if (ic_resp && !mon_ir) begin
            if (ic_exp_q.size() == 0) check("ic_resp_unexpected", ic_resp, 0);
            else check("ic_line", ic_line, ic_exp_q.pop_front());
        end
        mon_prev = dbg_state;
        mon_lr   = lsb_resp;
        mon_ir   = ic_resp;
    end

    task automatic lsb_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic sgn, input logic [31:0] wdata, input int exp_lat);
        logic got = 1'b0;
        if (!we) last_lsb_exp = load_model(addr, size, sgn);
        lsb_exp_q.push_back({32'h0, last_lsb_exp});
        @(posedge clk_in); #1;
        lsb_req = 1'b1; lsb_we = we; lsb_addr = addr; lsb_size = size;
        lsb_signed = sgn; lsb_wdata = wdata;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk_in);
            if (lsb_resp) got = 1'b1;
        end
        if (!got) check("lsb_timeout", got, 1);
        else check("lsb_latency", cyc - a_cyc, exp_lat);
        @(posedge clk_in); #1;
        lsb_req = 1'b0;
        @(negedge clk_in);
        check("lsb_resp_pulse", lsb_resp, 0);
        check("lsb_gap", dbg_state, ST_GAP);
    endtask

    task automatic ic_access(input logic [31:0] addr, input int exp_lat);
        logic got = 1'b0;
        int   step = 0;
        ic_exp_q.push_back(line_model(addr));
        @(posedge clk_in); #1;
        ic_req = 1'b1; ic_addr = addr;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk_in);
            if (dbg_state == ST_RD && step < LB) begin
                check("ic_ram_a", ram_a, AW'(addr + 32'(step)));
                step++;
            end
            if (ic_resp) got = 1'b1;
        end
        if (!got) check("ic_timeout", got, 1);
        else check("ic_latency", cyc - a_cyc, exp_lat);
        @(posedge clk_in); #1;
        ic_req = 1'b0;
        @(negedge clk_in);
        check("ic_resp_pulse", ic_resp, 0);
        check("ic_gap", dbg_state, ST_GAP);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_rnw"}, ram_rnw, 1);
        check({tag, "_ram_a"}, ram_a, 0);
        check({tag, "_ram_dout"}, ram_dout, 0);
        check({tag, "_ic_resp"}, ic_resp, 0);
        check({tag, "_lsb_resp"}, lsb_resp, 0);
        check({tag, "_ic_line"}, ic_line, 0);
        check({tag, "_lsb_rdata"}, lsb_rdata, 0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    initial begin
        #2_000_000;
        n_vec++; n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        logic [31:0] ra;
        logic [1:0]  rs;
        logic        rg;
        logic [7:0]  keep;
        int          nresp, r_loc;
        logic [2:0]  prev_st;

        for (int i = 0; i < 2048; i++) ram[i] = 8'($urandom_range(0, 255));
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h84;
        ram[12'h200] = 8'h9C;
        ram[12'h300] = 8'h34; ram[12'h301] = 8'h85;

        rst_n_in = 1'b0; rdy_in = 1'b1; uart_full_in = 1'b0;
        ic_req = 1'b0; ic_addr = '0;
        lsb_req = 1'b0; lsb_we = 1'b0; lsb_addr = '0; lsb_size = '0;
        lsb_signed = 1'b0; lsb_wdata = '0;
        repeat (3) @(negedge clk_in);
        check_reset_outputs("reset");
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        repeat (2) @(posedge clk_in);

        // loads: word, byte signed/unsigned, half, illegal size, random
        lsb_access(0, 32'h100, 2'd2, 1, 0, 5);
        lsb_access(0, 32'h200, 2'd0, 1, 0, 2);
        lsb_access(0, 32'h200, 2'd0, 0, 0, 2);
        lsb_access(0, 32'h300, 2'd1, 1, 0, 3);
        lsb_access(0, 32'h300, 2'd1, 0, 0, 3);
        lsb_access(0, 32'h100, 2'd3, 0, 0, 5);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom_range(32'h400, 32'h4F0);
            rs = 2'($urandom_range(0, 3));
            rg = 1'($urandom_range(0, 1));
            lsb_access(0, ra, rs, rg, 0, (rs == 2'd0 ? 1 : rs == 2'd1 ? 2 : 4) + 1);
        end

        ic_access(32'h40, 9);

        // memory stores: half then byte, neighbours untouched
        keep = ram[12'h502];
        lsb_access(1, 32'h500, 2'd1, 0, 32'hCAFEBEEF, 2);
        check("store_half", {ram[12'h501], ram[12'h500]}, 16'hBEEF);
        check("store_half_edge", ram[12'h502], keep);
        lsb_access(1, 32'h510, 2'd0, 0, 32'h1234565A, 1);
        check("store_byte", ram[12'h510], 8'h5A);
        lsb_access(0, 32'h500, 2'd2, 0, 0, 5);

        // UART store with three full cycles after byte 1
        uart_q.delete();
        fork
            lsb_access(1, IOB, 2'd2, 0, 32'h44434241, 7);
            begin
                repeat (4) @(posedge clk_in);
                #1 uart_full_in = 1'b1;
                repeat (3) begin
                    @(negedge clk_in);
                    check("stall_rnw", ram_rnw, 1);
                    @(posedge clk_in);
                end
                #1 uart_full_in = 1'b0;
            end
        join
        check("uart_count", uart_q.size(), 4);
        for (int i = 0; i < uart_q.size() && i < 4; i++) check("uart_byte", uart_q[i], 8'h41 + 8'(i));

        // rdy_in low for two cycles mid-load
        fork
            lsb_access(0, 32'h100, 2'd2, 1, 0, 7);
            begin
                repeat (3) @(posedge clk_in);
                #1 rdy_in = 1'b0;
                repeat (2) @(posedge clk_in);
                #1 rdy_in = 1'b1;
            end
        join

        // reset in the middle of an ICache fill
        @(posedge clk_in); #1;
        ic_req = 1'b1; ic_addr = 32'h80;
        repeat (4) @(posedge clk_in);
        #1 rst_n_in = 1'b0; ic_req = 1'b0;
        last_lsb_exp = 32'h0;
        @(negedge clk_in);
        check_reset_outputs("midfill_reset");
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        nresp = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (ic_resp) nresp++;
        end
        check("midfill_no_ic_resp", nresp, 0);

        // both requesters held continuously: LSB, IC, LSB, IC
        for (int i = 0; i < 2; i++) begin
            lsb_exp_q.push_back({32'h0, load_model(32'h100, 2'd2, 1)});
            ic_exp_q.push_back(line_model(32'h40));
        end
        @(posedge clk_in); #1;
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h100; lsb_size = 2'd2; lsb_signed = 1'b1;
        ic_req = 1'b1; ic_addr = 32'h40;
        nresp = 0; r_loc = 0; prev_st = dbg_state;
        for (int i = 0; i < 400 && nresp < 4; i++) begin
            @(negedge clk_in);
            if (dbg_state == ST_RD && prev_st == ST_IDLE && nresp > 0) check("rr_gap_to_accept", cyc - r_loc, 3);
            if (lsb_resp || ic_resp) begin
                check("rr_order", {lsb_resp, ic_resp}, (nresp % 2 == 0) ? 2'b10 : 2'b01);
                r_loc = cyc;
                nresp++;
            end
            prev_st = dbg_state;
        end
        check("rr_resp_count", nresp, 4);
        @(posedge clk_in); #1;
        lsb_req = 1'b0; ic_req = 1'b0;
        repeat (4) @(posedge clk_in);

        check("lsb_queue_drained", lsb_exp_q.size(), 0);
        check("ic_queue_drained", ic_exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_ctrl_burst.md
Name: mem_ctrl_burst

Overview:
- Parametrised successor of the CPU's single-port byte-serial memory controller.
- Arbitrates between ICache line fills and LSB load/store requests onto the 8-bit synchronous RAM/UART bus.
- ICache line size and address width are configurable.
- Adds round-robin fairness, signed/unsigned load extension, and UART-full stalls that never repeat a byte.

Parameters:
- ADDR_W, 18, RAM address width driven on ram_a.
- LINE_BYTES, 8, bytes per ICache fill (power of two, 4..32).
- IO_BASE, 32'h30000, requests with addr >= IO_BASE are I/O; UART-full stall applies to writes there.

Ports:
- clk_in  in  1  clock, all state on rising edge.
- rst_n_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global enable; 0 freezes all state and outputs.
- uart_full_in  in  1  UART TX buffer full.
- ram_din  in  8  RAM read byte, valid the cycle after its address.
- ram_dout  out  8  RAM write byte.
- ram_a  out  ADDR_W  RAM byte address.
- ram_rnw  out  1  1 = read, 0 = write.
- ic_req  in  1  ICache fill request, level, held until ic_resp.
- ic_addr  in  32  line base address, LINE_BYTES-aligned.
- ic_resp  out  1  one-cycle pulse, line valid.
- ic_line  out  8*LINE_BYTES  line data, byte k at bits [8k+7:8k].
- lsb_req  in  1  LSB request, level, held until lsb_resp.
- lsb_we  in  1  1 = store, 0 = load.
- lsb_addr  in  32  byte address.
- lsb_size  in  2  0 byte, 1 half, 2 word; 3 illegal, treated as word.
- lsb_signed  in  1  load sign-extends when 1.
- lsb_wdata  in  32  store data, little-endian.
- lsb_resp  out  1  one-cycle pulse, load data valid or store complete.
- lsb_rdata  out  32  extended load data.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, ram_rnw = 1, ram_a = 0, ram_dout = 0.
  - ic_resp = 0, lsb_resp = 0, ic_line = 0, lsb_rdata = 0.
  - last_grant = ICache, so the LSB wins the first tie.
  - Reset mid-transfer aborts the transfer; no resp is issued.
- States: IDLE, GAP, RD, WR, DONE.
- IDLE arbitration:
  - If only one request is high, grant it.
  - If both are high, grant the requester not in last_grant, then update last_grant.
  - The accept cycle (A) latches the granted request and drives ram_a = addr[ADDR_W-1:0], byte 0.
- Read (RD), N = LINE_BYTES for ICache, 1<<size for LSB:
  - Address of byte k is driven in cycle A+k.
  - Data for byte k is captured from ram_din at the end of cycle A+k+1.
  - After the last byte is captured, go to DONE; resp is high in cycle A+N+1.
  - ram_a increments by 1 per byte. Address wrap at 2^ADDR_W is natural modulo.
- Load extension:
  - Byte: bits [31:8] = sign of bit 7 if lsb_signed, else 0.
  - Half: bits [31:16] = sign of bit 15 if lsb_signed, else 0.
  - Word: no extension.
- Write (WR):
  - Byte k is driven with ram_rnw = 0 in cycle A+k, with ram_dout = wdata[8k+7:8k].
  - Stall: if addr >= IO_BASE and uart_full_in = 1 in a cycle, drive ram_rnw = 1 and hold k; the byte is re-driven when full deasserts, so each byte is written exactly once.
  - Memory writes never stall.
  - After the last byte, go to DONE; lsb_resp is high in the cycle after the last write cycle.
- DONE:
  - The matching resp is high for exactly one cycle; ram_rnw = 1, ram_a = 0.
  - Next state is GAP.
- GAP:
  - Lasts one cycle. All requests are ignored so the requester can drop its req.
  - Then return to IDLE.
- Outputs are registered. ic_line and lsb_rdata hold their value until the next transfer of the same type overwrites them.
- rdy_in = 0: all registers hold, including stall and byte counters; a held resp stays high.
- A request that drops before its grant is never granted.

Test Plan:
- Word load:
  - Stimulus: RAM[0x100..0x103] = 11,22,33,84; lsb_req word load, signed, addr 0x100.
  - Required: lsb_resp at A+5; lsb_rdata = 0x84332211; exactly one resp pulse, then GAP.
- Signed byte load:
  - Stimulus: RAM[0x200] = 0x9C; byte load with lsb_signed = 1, then lsb_signed = 0.
  - Required: lsb_rdata = 0xFFFFFF9C, then 0x0000009C.
- ICache fill:
  - Stimulus: ic_req addr 0x40, LINE_BYTES = 8.
  - Required: ram_a steps 0x40..0x47; ic_resp at A+9; ic_line = RAM bytes 0x40..0x47, little-endian.
- Simultaneous requests:
  - Stimulus: ic_req and lsb_req held continuously after reset.
  - Required: grants alternate LSB, IC, LSB, IC, ...; one GAP cycle between each resp and the next accept.
- UART stall:
  - Stimulus: word store 0x44434241 to 0x30000; uart_full_in high for 3 cycles after byte 1.
  - Required: bytes 41,42,43,44 each driven once with ram_rnw = 0; ram_rnw = 1 during the 3 stall cycles; resp delayed by 3 cycles.
- Reset and rdy_in:
  - Stimulus: rst_n_in pulsed low mid ICache fill; separately, rdy_in = 0 for 2 cycles mid-load.
  - Required: reset aborts the fill with no ic_resp and outputs return to reset values; the load completes 2 cycles late with correct data.
